// File: rtl/instr_mem_pipe_if.sv
// Fetch and load bus between the PC/fetch stage and the instruction memory.
// The master drives requests, flush and loads. The slave returns ready and the fetch results.
interface instr_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] address;
  logic              ready;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              valid;
  logic              fault;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output req, address, flush, ld_en, ld_addr, ld_data,
    input  ready, instr, valid, fault
  );

  modport slave (
    input  req, address, flush, ld_en, ld_addr, ld_data,
    output ready, instr, valid, fault
  );
endinterface

// File: rtl/instr_mem_pipe.sv
// Word-addressed instruction RAM with a run-time load port.
// Fetches pass through a fixed RD_LAT-stage pipeline with flush and fault reporting.
module instr_mem_pipe #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'b00111000100000000000000000000000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  instr_mem_pipe_if.slave  io_bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAST  = RD_LAT - 1;

  logic [DATA_W-1:0] r_mem  [DEPTH];
  logic [DATA_W-1:0] r_word [RD_LAT];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_flt;

  logic [ADDR_W-1:0] w_word_addr;
  logic [ADDR_W-1:0] w_ld_word_addr;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_ld_idx;
  logic              w_fault;
  logic              w_ld_ok;
  logic              w_accept;

  assign w_word_addr    = io_bus.address >> 2;
  assign w_ld_word_addr = io_bus.ld_addr >> 2;
  assign w_idx          = w_word_addr[IDX_W-1:0];
  assign w_ld_idx       = w_ld_word_addr[IDX_W-1:0];

  // Range checks use the full word address so out-of-range accesses never alias a real word.
  assign w_fault  = (io_bus.address[1:0] != 2'b00) || (w_word_addr >= ADDR_W'(DEPTH));
  assign w_ld_ok  = (w_ld_word_addr < ADDR_W'(DEPTH));

  assign io_bus.ready = i_rst_n && !io_bus.ld_en;
  assign w_accept     = io_bus.req && io_bus.ready;

  // The RAM and the data half of the pipeline have no reset. Only the valid and fault
  // bits qualify them, which keeps the storage mappable onto block RAM.
  always_ff @(posedge i_clk) begin
    if (io_bus.ld_en && w_ld_ok) begin
      r_mem[w_ld_idx] <= io_bus.ld_data;
    end
    if (w_accept) begin
      r_word[0] <= r_mem[w_idx];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      r_word[i] <= r_word[i-1];
    end
  end

  // A request accepted with flush enters stage 1 untouched; only older stages are killed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_flt <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_flt[0] <= w_accept && w_fault;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1] && !io_bus.flush;
        r_flt[i] <= r_flt[i-1];
      end
    end
  end

  assign io_bus.valid = r_vld[LAST];
  assign io_bus.fault = r_vld[LAST] && r_flt[LAST];
  assign io_bus.instr = (r_vld[LAST] && !r_flt[LAST]) ? r_word[LAST] : NOP_INSTR;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream.
// Both are checked against a per-request history model, a vector table and directed corner cases.
module tb_instr_mem_pipe;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h3880_0000;
  localparam int          HMAX  = 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  instr_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) if3 ();

  instr_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .NOP_INSTR(NOP)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if1.slave)
  );
  instr_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(3), .NOP_INSTR(NOP)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if3.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int base    = 0;

  // Model state: memory image plus one record per cycle of what was presented.
  logic [31:0] m_mem  [DEPTH];
  logic        h_acc  [HMAX];
  logic        h_flush[HMAX];
  logic        h_flt  [HMAX];
  logic [31:0] h_word [HMAX];

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        fl;
    logic        ld;
    logic [31:0] la;
    logic [31:0] ld_d;
    logic        ev;
    logic        ef;
    logic [31:0] ei;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic fl,
                              input logic ld, input logic [31:0] la, input logic [31:0] ld_d,
                              input logic ev, input logic ef, input logic [31:0] ei);
    vec_t v;
    v.req = req; v.addr = addr; v.fl = fl; v.ld = ld; v.la = la; v.ld_d = ld_d;
    v.ev = ev; v.ef = ef; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Result seen in cycle cyc for a lat-cycle pipe: the request from cyc-lat, unless a
  // flush arrived strictly after it was accepted and before it reached the output.
  task automatic model_out(input int lat, output logic v, output logic f, output logic [31:0] w);
    int c;
    c = cyc - lat;
    v = 1'b0; f = 1'b0; w = NOP;
    if (c >= base && h_acc[c]) begin
      v = 1'b1;
      for (int k = c + 1; k < cyc; k++) if (h_flush[k]) v = 1'b0;
      if (v) begin
        f = h_flt[c];
        w = h_word[c];
      end
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                       input logic ld, input logic [31:0] la, input logic [31:0] ld_d);
    if1.req = req; if1.address = addr; if1.flush = fl;
    if1.ld_en = ld; if1.ld_addr = la; if1.ld_data = ld_d;
    if3.req = req; if3.address = addr; if3.flush = fl;
    if3.ld_en = ld; if3.ld_addr = la; if3.ld_data = ld_d;
  endtask

  task automatic cycle(input logic req, input logic [31:0] addr, input logic fl,
                       input logic ld, input logic [31:0] la, input logic [31:0] ld_d);
    logic        v, f;
    logic [31:0] w, wa, lwa;
    drive(req, addr, fl, ld, la, ld_d);
    #1;
    chk("ready_L1", if1.ready, !ld);
    chk("ready_L3", if3.ready, !ld);
    wa = addr >> 2;
    h_acc[cyc]   = req && !ld;
    h_flush[cyc] = fl;
    h_flt[cyc]   = (addr[1:0] != 2'b00) || (wa >= DEPTH);
    h_word[cyc]  = h_flt[cyc] ? NOP : m_mem[wa[5:0]];
    $display("cyc %0d req=%0b addr=%h flush=%0b ld=%0b ld_addr=%h ld_data=%h",
             cyc, req, addr, fl, ld, la, ld_d);
    @(posedge clk);
    lwa = la >> 2;
    if (ld && lwa < DEPTH) m_mem[lwa[5:0]] = ld_d;
    if (cyc < HMAX - 1) cyc++;
    #1;
    model_out(1, v, f, w);
    chk("valid_L1", if1.valid, v);
    chk("fault_L1", if1.fault, f);
    chk("instr_L1", if1.instr, w);
    model_out(3, v, f, w);
    chk("valid_L3", if3.valid, v);
    chk("fault_L3", if3.fault, f);
    chk("instr_L3", if3.instr, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, la;
    int          sel;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    for (int i = 0; i < HMAX; i++) begin
      h_acc[i] = 1'b0; h_flush[i] = 1'b0; h_flt[i] = 1'b0; h_word[i] = NOP;
    end

    vt[0]  = mk(0, 32'h00, 0, 1, 32'h000, 32'h5800_0001, 0, 0, NOP);
    vt[1]  = mk(0, 32'h00, 0, 1, 32'h004, 32'h5808_0003, 0, 0, NOP);
    vt[2]  = mk(0, 32'h00, 0, 1, 32'h008, 32'h1088_1000, 0, 0, NOP);
    vt[3]  = mk(0, 32'h00, 0, 1, 32'h00C, 32'h2090_0003, 0, 0, NOP);
    vt[4]  = mk(1, 32'h00, 0, 0, 32'h000, 32'h0,         1, 0, 32'h5800_0001);
    vt[5]  = mk(1, 32'h04, 0, 0, 32'h000, 32'h0,         1, 0, 32'h5808_0003);
    vt[6]  = mk(1, 32'h08, 0, 0, 32'h000, 32'h0,         1, 0, 32'h1088_1000);
    vt[7]  = mk(1, 32'h0C, 0, 0, 32'h000, 32'h0,         1, 0, 32'h2090_0003);
    vt[8]  = mk(1, 32'h06, 0, 0, 32'h000, 32'h0,         1, 1, NOP);
    vt[9]  = mk(1, 32'h100, 0, 0, 32'h000, 32'h0,        1, 1, NOP);
    vt[10] = mk(1, 32'h10, 0, 1, 32'h010, 32'hDEAD_BEEF, 0, 0, NOP);
    vt[11] = mk(1, 32'h10, 0, 0, 32'h000, 32'h0,         1, 0, 32'hDEAD_BEEF);
    vt[12] = mk(1, 32'h00, 0, 1, 32'h100, 32'hCAFE_F00D, 0, 0, NOP);
    vt[13] = mk(1, 32'h00, 0, 0, 32'h000, 32'h0,         1, 0, 32'h5800_0001);
    vt[14] = mk(0, 32'h00, 0, 1, 32'h017, 32'h1234_5678, 0, 0, NOP);
    vt[15] = mk(1, 32'h14, 0, 0, 32'h000, 32'h0,         1, 0, 32'h1234_5678);
    vt[16] = mk(1, 32'h13, 0, 0, 32'h000, 32'h0,         1, 1, NOP);
    vt[17] = mk(0, 32'h00, 0, 0, 32'h000, 32'h0,         0, 0, NOP);

    // Reset state
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_valid_L1", if1.valid, 1'b0);
    chk("rst_fault_L1", if1.fault, 1'b0);
    chk("rst_instr_L1", if1.instr, NOP);
    chk("rst_ready_L1", if1.ready, 1'b0);
    chk("rst_valid_L3", if3.valid, 1'b0);
    chk("rst_instr_L3", if3.instr, NOP);
    chk("rst_ready_L3", if3.ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = cyc;

    // Vector table, expectations for the RD_LAT=1 instance in the following cycle
    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].req, vt[i].addr, vt[i].fl, vt[i].ld, vt[i].la, vt[i].ld_d);
      chk($sformatf("vec%0d_valid", i), if1.valid, vt[i].ev);
      chk($sformatf("vec%0d_fault", i), if1.fault, vt[i].ef);
      chk($sformatf("vec%0d_instr", i), if1.instr, vt[i].ei);
    end

    // RD_LAT=3 single fetch: valid in exactly the third cycle
    idle(3);
    cycle(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lat3_c1_valid", if3.valid, 1'b0);
    idle(1);
    chk("lat3_c2_valid", if3.valid, 1'b0);
    idle(1);
    chk("lat3_c3_valid", if3.valid, 1'b1);
    chk("lat3_c3_instr", if3.instr, 32'h5808_0003);
    idle(1);
    chk("lat3_c4_valid", if3.valid, 1'b0);

    // Flush with a same-cycle request: only the word at 40 emerges
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h28, 32'hA5A5_0040);
    idle(3);
    cycle(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h28, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("flush_f1_valid_L3", if3.valid, 1'b0);
    chk("flush_f1_instr_L1", if1.instr, 32'hA5A5_0040);
    idle(1);
    chk("flush_f2_valid_L3", if3.valid, 1'b0);
    idle(1);
    chk("flush_f3_valid_L3", if3.valid, 1'b1);
    chk("flush_f3_instr_L3", if3.instr, 32'hA5A5_0040);

    // Reset with fetches in flight
    idle(3);
    cycle(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid_L1", if1.valid, 1'b0);
    chk("midrst_valid_L3", if3.valid, 1'b0);
    chk("midrst_instr_L3", if3.instr, NOP);
    chk("midrst_ready_L3", if3.ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = cyc;
    idle(4);
    cycle(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    chk("postrst_instr_L3", if3.instr, 32'h2090_0003);

    // Fill memory, then random traffic against the model
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) addr = 32'((DEPTH + $urandom_range(0, 200)) * 4);
      else               addr = $urandom;
      la = (sel == 9) ? 32'((DEPTH + $urandom_range(0, 8)) * 4)
                      : 32'($urandom_range(0, DEPTH * 4 - 1));
      cycle($urandom_range(0, 99) < 70, addr, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 15, la, $urandom);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
